// File: rtl/reg_8.sv
// ----------------------------------------------------------------------------
// reg_8
// Parallel-load storage register with load enable and asynchronous clear.
// Captures d on a rising clk edge when ld is high, otherwise holds. A low rst
// forces q to RESET_VALUE immediately, independent of clk.
//
// Parameters:
//   WIDTH        data width in bits (default 8)
//   RESET_VALUE  value driven on q while rst is low (default all zeros)
//
// Ports:
//   clk  in   1      system clock, rising-edge active
//   rst  in   1      asynchronous reset, active-low
//   ld   in   1      load enable, active-high, sampled on rising clk
//   d    in   WIDTH  parallel data in
//   q    out  WIDTH  registered data out, straight from the storage flops
// ----------------------------------------------------------------------------
module reg_8 #(
    parameter int unsigned            WIDTH       = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset sits in the sensitivity list so the clear takes effect without a
    // clock; reset also wins over a coincident load edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_reg_8.sv
// ----------------------------------------------------------------------------
// tb_reg_8
// Self-checking bench for reg_8: directed sequence following the register's
// documented timeline, then randomized traffic compared against a behavioural
// model of "what value should the register be holding now".
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_8;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] RST_VAL = '0;

    logic             clk;
    logic             rst;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    int checks;
    int errors;

    // model: the value the register is supposed to hold
    logic [WIDTH-1:0] held;

    reg_8 #(.WIDTH(WIDTH), .RESET_VALUE(RST_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .d   (d),
        .q   (q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;   // rising edges at 10, 30, 50, ...

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: q=%h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic goto(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        logic [WIDTH-1:0] stream [4];
        checks = 0;
        errors = 0;
        stream[0] = 8'hA5; stream[1] = 8'h5A; stream[2] = 8'hFF; stream[3] = 8'h00;

        // initial load
        rst = 1'b1; ld = 1'b1; d = 8'h01;
        goto(5);   check("init_x", q, 'x);
        goto(11);  check("init_load", q, 8'h01);

        // async clear mid-cycle
        goto(25);  rst = 1'b0; ld = 1'b0;
        #0.1;      check("async_clear", q, 8'h00);
        goto(31);  check("clear_hold_edge", q, 8'h00);

        // release and reload
        goto(35);  rst = 1'b1;
        #1;        check("release_no_effect", q, 8'h00);
        goto(45);  ld = 1'b1; d = 8'h02;
        goto(51);  check("reload", q, 8'h02);

        // hold with d changing
        goto(65);  ld = 1'b0; d = 8'h99;
        goto(71);  check("hold_70", q, 8'h02);
        goto(91);  check("hold_90", q, 8'h02);
        goto(111); check("hold_110", q, 8'h02);

        // reset beats load
        goto(115); rst = 1'b0; ld = 1'b1; d = 8'hFF;
        #1;        check("rst_vs_ld_now", q, 8'h00);
        goto(131); check("rst_vs_ld_130", q, 8'h00);
        goto(151); check("rst_vs_ld_150", q, 8'h00);
        goto(171); check("rst_vs_ld_170", q, 8'h00);
        goto(175); rst = 1'b1;
        #1;        check("rst_release", q, 8'h00);
        goto(191); check("load_after_release", q, 8'hFF);

        // streaming load: q follows d one cycle later
        for (int i = 0; i < 4; i++) begin
            goto(195 + 20*i); d = stream[i];
            #1;               check("stream_pre", q, (i == 0) ? 8'hFF : stream[i-1]);
            goto(211 + 20*i); check("stream", q, stream[i]);
        end

        // randomized traffic against the model
        held = stream[3];
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 9) != 0);
            ld  = $urandom_range(0, 1);
            d   = WIDTH'($urandom);
            if (!rst) held = RST_VAL;
            #1 check("rand_async", q, held);
            // disturb d between edges; must not matter until the edge
            #3 d = WIDTH'($urandom);
            @(posedge clk);
            if (rst && ld) held = d;
            #1 check("rand_edge", q, held);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // absolute time guard so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout at %0t: checks=%0d expected completion", $time, checks);
        $fatal(1, "timeout");
    end

endmodule
